// File: rtl/uart_tx_refclk.sv
// UART transmitter whose bit timing is paced by rising edges of an external refclk strobe.
// Each bit lasts OVERSAMPLE ref_tick edges; the word arrives over a valid/ready handshake.
module uart_tx_refclk #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ref_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 txd,
   output logic                 tx_busy,
   output logic                 tx_done
);
   localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BIT_W  = 4;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               state;
   logic                 ref_prev;
   logic [TICK_W-1:0]    tick_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] word;
   logic                 tick_edge;
   logic                 bit_end;
   logic                 parity_bit;

   assign tick_edge  = ref_tick & ~ref_prev;
   assign bit_end    = tick_edge && (tick_cnt == TICK_LAST);
   assign parity_bit = (PARITY == 2) ? ~^word : ^word;

   // One register block: edge detector, tick pacing and the frame FSM with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         txd      <= 1'b1;
         tx_ready <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
         ref_prev <= 1'b1;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         word     <= '0;
      end else begin
         ref_prev <= ref_tick;
         tx_done  <= 1'b0;
         if (state != IDLE && tick_edge) begin
            tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
         end
         case (state)
            IDLE: begin
               if (tx_valid) begin
                  shift    <= tx_data;
                  word     <= tx_data;
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= START;
                  txd      <= 1'b0;
                  tx_ready <= 1'b0;
                  tx_busy  <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  state <= DATA;
                  txd   <= shift[0];
                  shift <= shift >> 1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     if (PARITY != 0) begin
                        state <= PAR;
                        txd   <= parity_bit;
                     end else begin
                        state <= STOP;
                        txd   <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     txd     <= shift[0];
                     shift   <= shift >> 1;
                  end
               end
            end
            PAR: begin
               if (bit_end) begin
                  state <= STOP;
                  txd   <= 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (bit_cnt == STOP_LAST) begin
                     state    <= IDLE;
                     bit_cnt  <= '0;
                     tx_ready <= 1'b1;
                     tx_busy  <= 1'b0;
                     tx_done  <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_refclk.sv
// Bench for uart_tx_refclk: five parameter variants share one refclk strobe; a frame-level
// model predicts txd and the handshake flags each cycle from counted ref_tick edges.
module tb_uart_tx_refclk;
   localparam int N = 5;
   localparam int DB_OF   [N] = '{8, 8, 8, 8, 5};
   localparam int OS_OF   [N] = '{16, 16, 16, 1, 3};
   localparam int PAR_OF  [N] = '{0, 1, 2, 0, 2};
   localparam int STOP_OF [N] = '{1, 1, 1, 1, 2};
   localparam int TICK_PERIOD = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         ref_tick;
   logic [8:0]   data_v [N];
   logic [N-1:0] valid_v;
   logic [N-1:0] ready_v;
   logic [N-1:0] txd_v;
   logic [N-1:0] busy_v;
   logic [N-1:0] done_v;

   int  compared;
   int  mismatched;
   int  phase;
   bit  tick_run;
   bit  ref_seen;
   bit  ref_last;
   bit  edge_seen;

   always #5 clk = ~clk;

   uart_tx_refclk #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst(rst), .ref_tick(ref_tick), .tx_data(data_v[0][7:0]), .tx_valid(valid_v[0]),
      .tx_ready(ready_v[0]), .txd(txd_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
   uart_tx_refclk #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst(rst), .ref_tick(ref_tick), .tx_data(data_v[1][7:0]), .tx_valid(valid_v[1]),
      .tx_ready(ready_v[1]), .txd(txd_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
   uart_tx_refclk #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) dut2 (
      .clk(clk), .rst(rst), .ref_tick(ref_tick), .tx_data(data_v[2][7:0]), .tx_valid(valid_v[2]),
      .tx_ready(ready_v[2]), .txd(txd_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
   uart_tx_refclk #(.DATA_BITS(8), .OVERSAMPLE(1), .PARITY(0), .STOP_BITS(1)) dut3 (
      .clk(clk), .rst(rst), .ref_tick(ref_tick), .tx_data(data_v[3][7:0]), .tx_valid(valid_v[3]),
      .tx_ready(ready_v[3]), .txd(txd_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));
   uart_tx_refclk #(.DATA_BITS(5), .OVERSAMPLE(3), .PARITY(2), .STOP_BITS(2)) dut4 (
      .clk(clk), .rst(rst), .ref_tick(ref_tick), .tx_data(data_v[4][4:0]), .tx_valid(valid_v[4]),
      .tx_ready(ready_v[4]), .txd(txd_v[4]), .tx_busy(busy_v[4]), .tx_done(done_v[4]));

   // Advance one clock; outputs are read 1 ns after the edge, and the strobe for the next edge is set.
   task automatic step();
      ref_seen = ref_tick;
      @(posedge clk);
      #1;
      edge_seen = ref_seen & ~ref_last;
      ref_last  = ref_seen;
      if (tick_run) begin
         phase    = (phase + 1) % TICK_PERIOD;
         ref_tick = (phase == 0);
      end else begin
         ref_tick = 1'b0;
      end
   endtask

   task automatic run_frame(input int k, input logic [8:0] word, input bit keep_valid,
                            input bit align, input int stall_at, input int abort_at);
      bit         exp_q[$];
      bit         obs [16];
      int         ones;
      int         nb;
      int         edges;
      int         idx;
      int         cyc;
      int         stall_end;
      bit         exp_busy;
      bit         exp_txd;
      bit         exp_done;
      logic [8:0] dec;
      logic [8:0] wm;
      exp_q.delete();
      ones = 0;
      wm   = '0;
      exp_q.push_back(1'b0);
      for (int i = 0; i < DB_OF[k]; i++) begin
         exp_q.push_back(word[i]);
         wm[i] = word[i];
         ones += int'(word[i]);
      end
      if (PAR_OF[k] == 1) exp_q.push_back(bit'(ones % 2));
      if (PAR_OF[k] == 2) exp_q.push_back(bit'(1 - ones % 2));
      for (int i = 0; i < STOP_OF[k]; i++) exp_q.push_back(1'b1);
      nb = exp_q.size();

      if (align) begin
         while (ref_tick !== 1'b1) step();
      end
      compared++;
      if (txd_v[k] !== 1'b1 || ready_v[k] !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL pre_accept k=%0d: txd=%b ready=%b, expected 1 1", k, txd_v[k], ready_v[k]);
      end
      data_v[k]  = word;
      valid_v[k] = 1'b1;
      step();
      if (!keep_valid) valid_v[k] = 1'b0;
      data_v[k] = 9'($urandom);

      edges     = 0;
      cyc       = 0;
      stall_end = -1;
      forever begin
         idx      = edges / OS_OF[k];
         exp_busy = (idx < nb);
         exp_txd  = exp_busy ? exp_q[idx] : 1'b1;
         exp_done = (idx == nb);
         compared++;
         if (txd_v[k] !== exp_txd || busy_v[k] !== exp_busy || ready_v[k] !== !exp_busy ||
             done_v[k] !== exp_done) begin
            mismatched++;
            if (mismatched <= 20)
               $display("[TB] FAIL frame k=%0d word=%h cyc=%0d bit=%0d: txd,busy,ready,done=%b%b%b%b expected %b%b%b%b",
                        k, word, cyc, idx, txd_v[k], busy_v[k], ready_v[k], done_v[k],
                        exp_txd, exp_busy, !exp_busy, exp_done);
         end
         if (exp_busy) obs[idx] = txd_v[k];
         if (!exp_busy) break;
         if (cyc == abort_at) begin
            rst = 1'b1;
            #1;
            compared++;
            if (txd_v[k] !== 1'b1 || busy_v[k] !== 1'b0 || ready_v[k] !== 1'b1 || done_v[k] !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL abort_immediate k=%0d: txd,busy,ready,done=%b%b%b%b expected 1010",
                        k, txd_v[k], busy_v[k], ready_v[k], done_v[k]);
            end
            step();
            compared++;
            if (txd_v[k] !== 1'b1 || done_v[k] !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL abort_no_done k=%0d: txd=%b done=%b expected 1 0", k, txd_v[k], done_v[k]);
            end
            rst = 1'b0;
            return;
         end
         if (cyc == stall_at) begin
            tick_run  = 1'b0;
            stall_end = cyc + 1000;
         end
         if (cyc == stall_end) tick_run = 1'b1;
         if (cyc >= 8000) begin
            mismatched++;
            $display("[TB] FAIL frame_timeout k=%0d: still at bit %0d of %0d after %0d clk", k, idx, nb, cyc);
            return;
         end
         step();
         cyc++;
         if (edge_seen) edges++;
      end

      dec = '0;
      for (int i = 0; i < DB_OF[k]; i++) dec[i] = obs[i + 1];
      compared++;
      if (dec !== wm) begin
         mismatched++;
         $display("[TB] FAIL decode k=%0d: got %h, expected %h", k, dec, wm);
      end
      if (!keep_valid) begin
         step();
         compared++;
         if (done_v[k] !== 1'b0 || ready_v[k] !== 1'b1 || txd_v[k] !== 1'b1 || busy_v[k] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL post_frame k=%0d: done,ready,txd,busy=%b%b%b%b expected 0110",
                     k, done_v[k], ready_v[k], txd_v[k], busy_v[k]);
         end
      end
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      valid_v = '1;
      for (int k = 0; k < N; k++) data_v[k] = 9'($urandom);
      #1;
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < N; k++) begin
            compared++;
            if (txd_v[k] !== 1'b1 || ready_v[k] !== 1'b1 || busy_v[k] !== 1'b0 || done_v[k] !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL reset k=%0d c=%0d: txd,ready,busy,done=%b%b%b%b expected 1100",
                        k, c, txd_v[k], ready_v[k], busy_v[k], done_v[k]);
            end
         end
         if (c < 3) step();
      end
      valid_v = '0;
      rst     = 1'b0;
      step();
      step();
      for (int k = 0; k < N; k++) begin
         compared++;
         if (txd_v[k] !== 1'b1 || busy_v[k] !== 1'b0 || ready_v[k] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_release k=%0d: txd,busy,ready=%b%b%b expected 101",
                     k, txd_v[k], busy_v[k], ready_v[k]);
         end
      end
   endtask

   task automatic test_basic();
      run_frame(0, 9'h055, 1'b0, 1'b0, -1, -1);
      run_frame(0, 9'($urandom), 1'b0, 1'b0, -1, -1);
   endtask

   task automatic test_parity();
      run_frame(1, 9'h0A5, 1'b0, 1'b0, -1, -1);
      run_frame(2, 9'h0A5, 1'b0, 1'b0, -1, -1);
      run_frame(1, 9'($urandom), 1'b0, 1'b1, -1, -1);
      run_frame(2, 9'($urandom), 1'b0, 1'b0, -1, -1);
   endtask

   task automatic test_back_to_back();
      run_frame(0, 9'h00F, 1'b1, 1'b0, -1, -1);
      run_frame(0, 9'h0F0, 1'b0, 1'b0, -1, -1);
   endtask

   task automatic test_reset_mid_frame();
      run_frame(0, 9'h000, 1'b0, 1'b0, -1, 868);
      step();
      run_frame(0, 9'h081, 1'b0, 1'b0, -1, -1);
   endtask

   task automatic test_stall();
      run_frame(0, 9'($urandom), 1'b0, 1'b1, 3, -1);
      run_frame(3, 9'h03C, 1'b0, 1'b0, 2, -1);
   endtask

   task automatic test_small_oversample();
      for (int i = 0; i < 4; i++) run_frame(3, 9'($urandom), 1'b0, (i == 1), -1, -1);
      for (int i = 0; i < 3; i++) run_frame(4, 9'($urandom), (i == 0), (i == 2), -1, -1);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      ref_tick   = 1'b0;
      ref_last   = 1'b1;
      tick_run   = 1'b1;
      phase      = int'($urandom_range(0, TICK_PERIOD - 1));
      test_reset();
      test_basic();
      test_parity();
      test_back_to_back();
      test_reset_mid_frame();
      test_stall();
      test_small_oversample();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
